cordic_mag_stats: RTL and testbench
===================================

Name: cordic_mag_stats

Overview:
- Downstream consumer of cordic_top in magnitude mode (mode 0); reduces the r_out magnitude stream to per-frame statistics.
- cordic_top carries no valid signal, so this block delays the upstream sample-valid by the fixed CORDIC pipeline latency to align it with r_out.
- Per frame of programmable length it reports the peak magnitude, the peak's index and the magnitude sum through a valid/ready result port with a single holding register.

Parameters:
- D_WIDTH, 16, magnitude width; equals cordic_top D_WIDTH.
- LEN_W, 8, frame-length and index width.
- LAT, 18, delay from cordic_top x_in/y_in to r_out in cycles; must equal CORDIC_DELAY+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  high in the same cycle a sample is presented on cordic_top x_in/y_in with mode=0.
- mag_in  in  D_WIDTH  cordic_top r_out, unsigned.
- frame_len  in  LEN_W  samples per frame; 0 means 2^LEN_W.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_max  out  D_WIDTH  peak magnitude of the frame.
- res_max_idx  out  LEN_W  index of the first occurrence of the peak within the frame (0-based).
- res_sum  out  D_WIDTH+LEN_W  sum of all magnitudes in the frame; this width cannot overflow.
- res_dropped  out  1  one-cycle pulse when a completed frame is discarded.

Behaviour:
- Reset: all state and outputs are 0, including the valid delay line, the FSM (IDLE), counters and accumulators. Samples in flight at reset are lost.
- Alignment: a LAT-deep shift register on s_valid produces v_al. A sample counts only when v_al=1, and mag_in is taken in that same cycle.
- FSM states: IDLE and ACC.
- IDLE, on v_al:
  - latch len = (frame_len==0 ? 2^LEN_W : frame_len) into a LEN_W+1 bit register;
  - set max=mag_in, idx=0, sum=mag_in, cnt=1;
  - if len==1, publish immediately and stay in IDLE; otherwise go to ACC.
- ACC, on v_al:
  - sum += mag_in;
  - if mag_in > max (strict, so ties keep the earlier index), set max=mag_in and idx=cnt;
  - cnt++;
  - when the updated cnt equals len, publish and return to IDLE.
- ACC with v_al=0: hold all state. Gaps are allowed and there is no timeout.
- frame_len is sampled only on the first sample of a frame; changes mid-frame are ignored.
- Publish, in the cycle after the last aligned sample:
  - if res_valid==0, or res_valid==1 and res_ready==1 in the completing cycle, load res_* and set res_valid=1;
  - otherwise keep the held result unchanged and pulse res_dropped for one cycle.
- Handshake:
  - res_valid falls on the cycle after res_valid&res_ready, unless a new publish loads in that same cycle.
  - res_* are stable while res_valid=1 and res_ready=0.
- Latency: last sample at cordic_top input in cycle t gives res_valid high at cycle t+LAT+1.
- Back-to-back frames: a frame may start on the aligned sample immediately after the completing one, with no bubble.
- mag_in values are ignored while v_al=0.

Decomposition:
- Shared include (cordic_inc.v): D_WIDTH and CORDIC_DELAY, plus a derived constant MAG_LAT = CORDIC_DELAY+1 used as the LAT default at instantiation.
- Sub-module valid_delay (parameter DEPTH; 1-bit async-reset shift register).
- The accumulator, FSM and output register stay in the top.

Test Plan:
1. frame_len=4, mags 3,7,7,2 on consecutive aligned cycles, res_ready=1 -> res_max=7, res_max_idx=1, res_sum=19; res_valid high 1 cycle at t_last+LAT+1.
2. frame_len=1, mags 5,9 back-to-back -> two results (5,0,5) then (9,0,9) on consecutive cycles, no drop.
3. frame_len=0, 256 samples of 0xFFFF with valid gaps every 3rd cycle -> res_sum=0xFFFF00, res_max=0xFFFF, res_max_idx=0.
4. res_ready=0, two frames of len 2 (1,2) then (4,3) -> first result (2,1,3) held stable, res_dropped pulses once at second completion; then res_ready=1 -> one handshake, res_valid falls.
5. Result pending with res_ready=1 in the same cycle a new frame completes -> no drop, new values load, res_valid stays 1.
6. rst_n low mid-frame (after 2 of 4 samples) with samples still in the delay line -> all outputs 0; after release, a fresh len-3 frame 1,1,1 yields (1,0,3) with no residue from before reset.

Source files
------------

// File: rtl/cordic_mag_stats_pkg.sv
// Shared constants and types for the CORDIC magnitude statistics slice.
// MAG_LAT is the cycle count from cordic_top x_in/y_in to r_out.
package cordic_mag_stats_pkg;

    localparam int CORDIC_D_WIDTH = 16;
    localparam int CORDIC_DELAY   = 17;
    localparam int MAG_LAT        = CORDIC_DELAY + 1;
    localparam int STATS_LEN_W    = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

endpackage

// File: rtl/cordic_mag_stats_valid_delay.sv
// Fixed-depth 1-bit delay line that re-aligns the upstream sample-valid
// with the CORDIC magnitude output.
module valid_delay #(
    parameter int DEPTH = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] r_shift;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_shift <= '0;
                end else begin
                    r_shift <= i_valid;
                end
            end
        end else begin : g_many
            // NOTE: the delay line is reset so that samples in flight at reset never surface as phantom data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_shift <= '0;
                end else begin
                    r_shift <= {r_shift[DEPTH-2:0], i_valid};
                end
            end
        end
    endgenerate

    assign o_valid = r_shift[DEPTH-1];

endmodule

// File: rtl/cordic_mag_stats.sv
// Reduces the cordic_top magnitude stream to per-frame peak, peak index and
// sum, published through a single-entry valid/ready result register.
module cordic_mag_stats
    import cordic_mag_stats_pkg::*;
#(
    parameter int D_WIDTH = CORDIC_D_WIDTH,
    parameter int LEN_W   = STATS_LEN_W,
    parameter int LAT     = MAG_LAT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    input  logic [D_WIDTH-1:0]       mag_in,
    input  logic [LEN_W-1:0]         frame_len,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [D_WIDTH-1:0]       res_max,
    output logic [LEN_W-1:0]         res_max_idx,
    output logic [D_WIDTH+LEN_W-1:0] res_sum,
    output logic                     res_dropped
);

    localparam int CNT_W = LEN_W + 1;
    localparam int SUM_W = D_WIDTH + LEN_W;
    localparam logic [CNT_W-1:0] FULL_LEN = {1'b1, {LEN_W{1'b0}}};
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic                 w_v_al;
    logic [CNT_W-1:0]     w_first_len;
    logic                 w_publish;
    logic                 w_load;

    state_e               r_state;
    state_e               w_state_nxt;
    logic [CNT_W-1:0]     r_len;
    logic [CNT_W-1:0]     w_len_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [D_WIDTH-1:0]   r_max;
    logic [D_WIDTH-1:0]   w_max_nxt;
    logic [LEN_W-1:0]     r_idx;
    logic [LEN_W-1:0]     w_idx_nxt;
    logic [SUM_W-1:0]     r_sum;
    logic [SUM_W-1:0]     w_sum_nxt;

    logic                 r_res_valid;
    logic [D_WIDTH-1:0]   r_res_max;
    logic [LEN_W-1:0]     r_res_max_idx;
    logic [SUM_W-1:0]     r_res_sum;
    logic                 r_res_dropped;

    valid_delay #(
        .DEPTH   (LAT)
    ) u_valid_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (s_valid),
        .o_valid (w_v_al)
    );

    assign w_first_len = (frame_len == '0) ? FULL_LEN : {1'b0, frame_len};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_max_nxt   = r_max;
        w_idx_nxt   = r_idx;
        w_sum_nxt   = r_sum;
        w_publish   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_v_al) begin
                    w_len_nxt = w_first_len;
                    w_max_nxt = mag_in;
                    w_idx_nxt = '0;
                    w_sum_nxt = SUM_W'(mag_in);
                    w_cnt_nxt = ONE_CNT;
                    if (w_first_len == ONE_CNT) begin
                        w_publish = 1'b1;
                    end else begin
                        w_state_nxt = ST_ACC;
                    end
                end
            end
            ST_ACC: begin
                if (w_v_al) begin
                    w_sum_nxt = r_sum + SUM_W'(mag_in);
                    // Strict compare keeps the first occurrence of a tied peak.
                    if (mag_in > r_max) begin
                        w_max_nxt = mag_in;
                        w_idx_nxt = r_cnt[LEN_W-1:0];
                    end
                    w_cnt_nxt = r_cnt + ONE_CNT;
                    if (w_cnt_nxt == r_len) begin
                        w_publish   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
            r_cnt <= '0;
            r_max <= '0;
            r_idx <= '0;
            r_sum <= '0;
        end else begin
            r_len <= w_len_nxt;
            r_cnt <= w_cnt_nxt;
            r_max <= w_max_nxt;
            r_idx <= w_idx_nxt;
            r_sum <= w_sum_nxt;
        end
    end

    // A completed frame loads only if the holding register is empty or being drained.
    assign w_load = w_publish && (!r_res_valid || res_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid   <= 1'b0;
            r_res_max     <= '0;
            r_res_max_idx <= '0;
            r_res_sum     <= '0;
            r_res_dropped <= 1'b0;
        end else begin
            r_res_dropped <= w_publish && !w_load;
            if (w_load) begin
                r_res_valid   <= 1'b1;
                r_res_max     <= w_max_nxt;
                r_res_max_idx <= w_idx_nxt;
                r_res_sum     <= w_sum_nxt;
            end else if (res_ready) begin
                r_res_valid   <= 1'b0;
            end
        end
    end

    assign res_valid   = r_res_valid;
    assign res_max     = r_res_max;
    assign res_max_idx = r_res_max_idx;
    assign res_sum     = r_res_sum;
    assign res_dropped = r_res_dropped;

endmodule

// File: tb/tb_cordic_mag_stats.sv
// Self-checking bench: directed scenarios then randomized traffic, compared
// cycle by cycle against a frame-level reference model.
module tb_cordic_mag_stats;
    import cordic_mag_stats_pkg::*;

    localparam int DW  = 16;
    localparam int LW  = 8;
    localparam int LAT = MAG_LAT;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_valid = 1'b0;
    logic [DW-1:0]   mag_in = '0;
    logic [LW-1:0]   frame_len = '0;
    logic            res_ready = 1'b0;
    logic            res_valid;
    logic [DW-1:0]   res_max;
    logic [LW-1:0]   res_max_idx;
    logic [DW+LW-1:0] res_sum;
    logic            res_dropped;

    always #5 clk = ~clk;

    cordic_mag_stats #(
        .D_WIDTH     (DW),
        .LEN_W       (LW),
        .LAT         (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .mag_in      (mag_in),
        .frame_len   (frame_len),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_max     (res_max),
        .res_max_idx (res_max_idx),
        .res_sum     (res_sum),
        .res_dropped (res_dropped)
    );

    int checks = 0;
    int errors = 0;

    // Upstream model: what cordic_top would present on r_out LAT cycles later.
    bit pipe_v[$];
    int pipe_m[$];

    // Frame-level reference model.
    int     frame_q[$];
    int     frame_target;
    bit     m_rv;
    bit     m_drop;
    int     m_max;
    int     m_idx;
    longint m_sum;

    // Observation helpers for directed checks.
    int     cyc;
    int     drop_seen;
    int     rv_hi;
    int     rise_cyc;
    bit     prev_rv;
    int     cap_max;
    int     cap_idx;
    longint cap_sum;
    int     t_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pipe_v.delete();
        pipe_m.delete();
        for (int i = 0; i < LAT; i++) begin
            pipe_v.push_back(1'b0);
            pipe_m.push_back(0);
        end
        frame_q.delete();
        frame_target = 0;
        m_rv    = 1'b0;
        m_drop  = 1'b0;
        m_max   = 0;
        m_idx   = 0;
        m_sum   = 0;
        prev_rv = 1'b0;
    endtask

    // One clock cycle: drive inputs at negedge, advance model at posedge, check at next negedge.
    task automatic step(input bit v, input int m, input bit rdy);
        bit     av;
        int     am;
        bit     pub;
        int     p_max;
        int     p_idx;
        longint p_sum;
        s_valid   = v;
        res_ready = rdy;
        pipe_v.push_back(v);
        pipe_m.push_back(m);
        av = pipe_v.pop_front();
        am = pipe_m.pop_front();
        mag_in = av ? DW'(am) : DW'($urandom);
        pub   = 1'b0;
        p_max = 0;
        p_idx = 0;
        p_sum = 0;
        if (av) begin
            if (frame_q.size() == 0) begin
                frame_target = (frame_len == '0) ? (1 << LW) : int'(frame_len);
            end
            frame_q.push_back(am);
            if (frame_q.size() == frame_target) begin
                pub   = 1'b1;
                p_max = frame_q[0];
                foreach (frame_q[i]) begin
                    p_sum += frame_q[i];
                    if (frame_q[i] > p_max) begin
                        p_max = frame_q[i];
                        p_idx = i;
                    end
                end
                frame_q.delete();
            end
        end
        @(posedge clk);
        m_drop = 1'b0;
        if (pub && (!m_rv || rdy)) begin
            m_rv  = 1'b1;
            m_max = p_max;
            m_idx = p_idx;
            m_sum = p_sum;
        end else begin
            if (pub) m_drop = 1'b1;
            if (rdy) m_rv = 1'b0;
        end
        @(negedge clk);
        cyc++;
        check("res_valid", res_valid, m_rv);
        check("res_dropped", res_dropped, m_drop);
        check("res_max", res_max, m_max);
        check("res_max_idx", res_max_idx, m_idx);
        check("res_sum", res_sum, m_sum);
        if (res_dropped) drop_seen++;
        if (res_valid) rv_hi++;
        if (res_valid && !prev_rv) begin
            if (rise_cyc < 0) rise_cyc = cyc;
            cap_max = int'(res_max);
            cap_idx = int'(res_max_idx);
            cap_sum = longint'(res_sum);
        end
        prev_rv = res_valid;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 0, rdy);
    endtask

    initial begin
        int sent;
        int k;
        model_reset();
        cyc       = 0;
        drop_seen = 0;
        rise_cyc  = -1;
        rst_n     = 1'b0;
        res_ready = 1'b1;
        frame_len = 8'd4;
        repeat (2) @(negedge clk);
        check("reset_valid", res_valid, 0);
        check("reset_sum", res_sum, 0);
        check("reset_dropped", res_dropped, 0);
        rst_n = 1'b1;

        // Frame of four with a tied peak; check latency from last input sample.
        frame_len = 8'd4;
        rise_cyc  = -1;
        step(1'b1, 3, 1'b1);
        step(1'b1, 7, 1'b1);
        step(1'b1, 7, 1'b1);
        t_last = cyc;
        step(1'b1, 2, 1'b1);
        idle(LAT + 3, 1'b1);
        check("t1_latency", rise_cyc, t_last + LAT + 1);
        check("t1_max", cap_max, 7);
        check("t1_idx", cap_idx, 1);
        check("t1_sum", cap_sum, 19);

        // Single-sample frames back to back.
        frame_len = 8'd1;
        drop_seen = 0;
        rv_hi     = 0;
        step(1'b1, 5, 1'b1);
        step(1'b1, 9, 1'b1);
        idle(LAT + 3, 1'b1);
        check("t2_drops", drop_seen, 0);
        check("t2_valid_cycles", rv_hi, 2);

        // Maximal frame length with periodic gaps.
        frame_len = 8'd0;
        sent = 0;
        k    = 0;
        while (sent < 256) begin
            if ((k % 3) != 2) begin
                step(1'b1, 16'hFFFF, 1'b1);
                sent++;
            end else begin
                step(1'b0, 0, 1'b1);
            end
            k++;
        end
        idle(LAT + 3, 1'b1);
        check("t3_max", cap_max, 16'hFFFF);
        check("t3_idx", cap_idx, 0);
        check("t3_sum", cap_sum, 24'hFFFF00);

        // Consumer stalled: second frame is dropped, first result held.
        frame_len = 8'd2;
        drop_seen = 0;
        step(1'b1, 1, 1'b0);
        step(1'b1, 2, 1'b0);
        step(1'b1, 4, 1'b0);
        step(1'b1, 3, 1'b0);
        idle(LAT + 4, 1'b0);
        check("t4_drops", drop_seen, 1);
        check("t4_held_valid", res_valid, 1);
        check("t4_held_max", res_max, 2);
        check("t4_held_idx", res_max_idx, 1);
        check("t4_held_sum", res_sum, 3);
        step(1'b0, 0, 1'b1);
        check("t4_after_hs", res_valid, 0);

        // Pending result drained in the same cycle a new frame completes.
        frame_len = 8'd1;
        step(1'b1, 11, 1'b0);
        idle(LAT + 2, 1'b0);
        drop_seen = 0;
        step(1'b1, 13, 1'b0);
        idle(LAT - 1, 1'b0);
        step(1'b0, 0, 1'b1);
        check("t5_drops", drop_seen, 0);
        check("t5_valid", res_valid, 1);
        check("t5_max", res_max, 13);
        step(1'b0, 0, 1'b1);

        // Reset mid-frame with samples still in the delay line.
        frame_len = 8'd4;
        step(1'b1, 9, 1'b1);
        step(1'b1, 9, 1'b1);
        idle(5, 1'b1);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("t6_rst_valid", res_valid, 0);
        check("t6_rst_max", res_max, 0);
        check("t6_rst_sum", res_sum, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        frame_len = 8'd3;
        rise_cyc  = -1;
        step(1'b1, 1, 1'b1);
        step(1'b1, 1, 1'b1);
        step(1'b1, 1, 1'b1);
        idle(LAT + 3, 1'b1);
        check("t6_max", cap_max, 1);
        check("t6_idx", cap_idx, 0);
        check("t6_sum", cap_sum, 3);

        // Random traffic: gaps, stalls and frame_len changing every cycle.
        for (int i = 0; i < 800; i++) begin
            frame_len = LW'($urandom_range(1, 5));
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)));
        end
        idle(LAT + 3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
